dispmem_arbiter: RTL and testbench
==================================

DISPMEM_ARBITER -- requirements
Module: dispmem_arbiter

Interface
REQ-001 Parameter NUM_WR, default 2: number of display-memory write requesters, legal range 1..4.
REQ-002 Parameter WR_VBLANK_ONLY, default 0: when 1, writes are granted only while v_visible_i=0.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst_ni  in  1  reset; synchronous, active-low.
REQ-005 v_visible_i  in  1  vertical-visible flag from video timing.
REQ-006 vid_rd_en_i / vid_rd_addr_i  in  1 / DISPADDR_W  video generator read request and address.
REQ-007 vid_rd_data_o  out  DISPDATA_W  read data returned to the video generator.
REQ-008 host_rd_req_i / host_rd_addr_i  in  1 / DISPADDR_W  host read request (level) and address.
REQ-009 host_rd_ack_o / host_rd_data_o  out  1 / DISPDATA_W  one-cycle ack pulse and registered read data.
REQ-010 wr_req_i / wr_ack_o  in / out  NUM_WR  per-requester write request (level) and one-cycle ack pulse.
REQ-011 wr_addr_i / wr_data_i  in  NUM_WR x DISPADDR_W / NUM_WR x DISPDATA_W  per-requester write address and data.
REQ-012 mem_rd_en_o / mem_rd_addr_o / mem_rd_data_i  out / out / in  1 / DISPADDR_W / DISPDATA_W  display memory read port; data valid 1 cycle after mem_rd_en_o.
REQ-013 mem_wr_en_o / mem_wr_addr_o / mem_wr_data_o  out  1 / DISPADDR_W / DISPDATA_W  display memory write port; all three registered.

Function
REQ-014 Video reads have absolute priority: when vid_rd_en_i=1, the block drives mem_rd_en_o=1 and mem_rd_addr_o=vid_rd_addr_i combinationally in the same cycle.
REQ-015 vid_rd_data_o equals mem_rd_data_i combinationally; the video read latency is 1 cycle, identical to a direct memory connection.
REQ-016 The host read FSM has three states: R_IDLE, R_PEND and R_DATA.
REQ-017 R_IDLE -> R_PEND when host_rd_req_i=1 and host_rd_ack_o=0; host_rd_addr_i is latched on this transition.
REQ-018 In R_PEND, during a cycle with vid_rd_en_i=0, the block drives the latched address onto the read port with mem_rd_en_o=1 and moves to R_DATA; otherwise it stays in R_PEND.
REQ-019 In R_DATA the block registers mem_rd_data_i into host_rd_data_o, pulses host_rd_ack_o for 1 cycle and returns to R_IDLE.
REQ-020 Host read latency is 3 cycles from request to ack when video is idle; it is unbounded while video reads back-to-back.
REQ-021 host_rd_data_o holds its value until the next host ack.
REQ-022 Writes are arbitrated round-robin among eligible requesters. Eligible means wr_req_i[n]=1 and wr_ack_o[n]=0 in that cycle, and, when WR_VBLANK_ONLY=1, v_visible_i=0.
REQ-023 On a grant to requester n in cycle N, in cycle N+1: mem_wr_en_o=1, mem_wr_addr_o/mem_wr_data_o = requester n's address/data sampled in cycle N, and wr_ack_o[n]=1.
REQ-024 At most one write is granted per cycle, so write throughput is 1 per cycle with two or more active requesters.
REQ-025 After a grant to requester n, requester n has the lowest priority; the remaining requesters are searched in order n+1, n+2, ... with wrap-around.
REQ-026 A requester holds its request, address and data stable until its ack and deasserts the request in the cycle after the ack. A request held longer is treated as a new request.
REQ-027 Writes and reads are independent ports; a write and a read to the same address in the same cycle follow the memory's behaviour, and the arbiter does not reorder them.
REQ-028 When WR_VBLANK_ONLY=1 and v_visible_i rises, no new grants are made; a write already registered still completes.

Reset
REQ-029 While rst_ni=0 at a clock edge, every registered output becomes 0: mem_wr_en_o, wr_ack_o, host_rd_ack_o and host_rd_data_o.
REQ-030 Reset also sets the read FSM to R_IDLE and the round-robin pointer to give requester 0 highest priority.
REQ-031 Reset during R_PEND/R_DATA or with a write pending discards that operation with no ack; requesters re-request after reset.
REQ-032 Combinational video read pass-through (REQ-014/015) is active regardless of reset.

Structure
REQ-033 arb_rd_state_t (R_IDLE/R_PEND/R_DATA) and the constant NUM_DISP_WR_MAX=4 reside in video_package, alongside the existing disp_addr_t and disp_data_t.
REQ-034 Round-robin selection is a separate sub-module, rr_arbiter, parameterised by NUM_WR: inputs are the request vector and a pointer, output is a one-hot grant.

Verification
REQ-035 Video 100% busy for 20 cycles, host read of addr 0x012 pending: no host mem_rd_en_o while video busy; the host access is issued in the first idle cycle and host_rd_ack_o follows 2 cycles later with the data at 0x012.
REQ-036 Two requesters both request continuously: grants alternate 0,1,0,1...; mem_wr_en_o is high every cycle; each ack is exactly 1 cycle wide.
REQ-037 Requester 1 writes 0x41 to addr 0x005, then host reads 0x005: host_rd_data_o=0x41.
REQ-038 WR_VBLANK_ONLY=1, request raised with v_visible_i=1: no ack until v_visible_i=0; the ack arrives 1 cycle after that.
REQ-039 rst_ni pulsed low while in R_PEND and with a write pending: no ack is ever produced; all outputs read 0 at the next cycle; state is R_IDLE.
REQ-040 Random video/host/write traffic for 10k cycles, checked against a scoreboard memory model: every write is applied exactly once, every host read returns the model value, and video data is never delayed.

Source files
------------

// File: rtl/dispmem_arbiter_pkg.sv
// Shared display-memory types: address/data words, the write payload and the
// host read FSM encoding used by dispmem_arbiter.
package video_package;

  localparam int unsigned DISPADDR_W      = 12;
  localparam int unsigned DISPDATA_W      = 8;
  localparam int unsigned NUM_DISP_WR_MAX = 4;
  localparam int unsigned WR_PTR_W        = 2;  // indexes up to NUM_DISP_WR_MAX requesters

  typedef logic [DISPADDR_W-1:0] disp_addr_t;
  typedef logic [DISPDATA_W-1:0] disp_data_t;

  typedef struct packed {
    disp_addr_t addr;
    disp_data_t data;
  } disp_wr_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_PEND = 2'd1,
    R_DATA = 2'd2
  } arb_rd_state_t;

endpackage

// File: rtl/dispmem_arbiter_rr_arbiter.sv
// Round-robin selector: one-hot grant to the first requester found searching
// upward from ptr with wrap-around.
module rr_arbiter
  import video_package::*;
#(
  parameter int unsigned NUM_WR = 2
) (
  input  logic [NUM_WR-1:0]   req,
  input  logic [WR_PTR_W-1:0] ptr,
  output logic [NUM_WR-1:0]   grant
);

  function automatic int rot_idx(input logic [WR_PTR_W-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    return (s >= int'(NUM_WR)) ? s - int'(NUM_WR) : s;
  endfunction

  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < int'(NUM_WR); i++) begin
      for (int n = 0; n < int'(NUM_WR); n++) begin
        if (!found && req[n] && (n == rot_idx(ptr, i))) begin
          grant[n] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dispmem_arbiter.sv
// Display-memory arbiter: video reads pass straight through with top priority,
// host reads steal idle read-port cycles, writers share the write port round-robin.
module dispmem_arbiter
  import video_package::*;
#(
  parameter int unsigned NUM_WR         = 2,
  parameter bit          WR_VBLANK_ONLY = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_ni,
  input  logic                    v_visible_i,
  input  logic                    vid_rd_en_i,
  input  disp_addr_t              vid_rd_addr_i,
  output disp_data_t              vid_rd_data_o,
  input  logic                    host_rd_req_i,
  input  disp_addr_t              host_rd_addr_i,
  output logic                    host_rd_ack_o,
  output disp_data_t              host_rd_data_o,
  input  logic [NUM_WR-1:0]       wr_req_i,
  output logic [NUM_WR-1:0]       wr_ack_o,
  input  disp_addr_t [NUM_WR-1:0] wr_addr_i,
  input  disp_data_t [NUM_WR-1:0] wr_data_i,
  output logic                    mem_rd_en_o,
  output disp_addr_t              mem_rd_addr_o,
  input  disp_data_t              mem_rd_data_i,
  output logic                    mem_wr_en_o,
  output disp_addr_t              mem_wr_addr_o,
  output disp_data_t              mem_wr_data_o
);

  arb_rd_state_t       rd_state;
  arb_rd_state_t       rd_state_nxt;
  disp_addr_t          host_addr_q;
  logic                host_accept;
  logic                host_issue;
  logic                host_done;

  logic                wr_open;
  logic [NUM_WR-1:0]   wr_elig;
  logic [NUM_WR-1:0]   wr_grant;
  logic [WR_PTR_W-1:0] wr_ptr;
  logic [WR_PTR_W-1:0] wr_ptr_nxt;
  disp_wr_t            wr_sel;

  // Host read FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      rd_state <= R_IDLE;
    end else begin
      rd_state <= rd_state_nxt;
    end
  end

  // Host read FSM: next state
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:  if (host_rd_req_i && !host_rd_ack_o) rd_state_nxt = R_PEND;
      R_PEND:  if (!vid_rd_en_i) rd_state_nxt = R_DATA;
      R_DATA:  rd_state_nxt = R_IDLE;
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // Host read FSM: outputs; video owns the read port whenever it asks
  always_comb begin
    host_accept   = (rd_state == R_IDLE) && host_rd_req_i && !host_rd_ack_o;
    host_issue    = (rd_state == R_PEND) && !vid_rd_en_i;
    host_done     = (rd_state == R_DATA);
    mem_rd_en_o   = vid_rd_en_i | host_issue;
    mem_rd_addr_o = vid_rd_en_i ? vid_rd_addr_i : host_addr_q;
    vid_rd_data_o = mem_rd_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      host_rd_ack_o  <= 1'b0;
      host_rd_data_o <= '0;
      host_addr_q    <= '0;
    end else begin
      host_rd_ack_o <= host_done;
      if (host_done)   host_rd_data_o <= mem_rd_data_i;
      if (host_accept) host_addr_q    <= host_rd_addr_i;
    end
  end

  // A requester already acked this cycle is treated as done, not re-requesting
  always_comb begin
    wr_open = !(WR_VBLANK_ONLY && v_visible_i);
    wr_elig = wr_open ? (wr_req_i & ~wr_ack_o) : '0;
  end

  rr_arbiter #(.NUM_WR(NUM_WR)) u_rr (
    .req   (wr_elig),
    .ptr   (wr_ptr),
    .grant (wr_grant)
  );

  // Winner's payload; the requester after the winner becomes highest priority
  always_comb begin
    wr_sel     = '0;
    wr_ptr_nxt = wr_ptr;
    for (int n = 0; n < int'(NUM_WR); n++) begin
      if (wr_grant[n]) begin
        wr_sel.addr = wr_addr_i[n];
        wr_sel.data = wr_data_i[n];
        wr_ptr_nxt  = (n == int'(NUM_WR) - 1) ? '0 : WR_PTR_W'(n + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      wr_ack_o      <= '0;
      mem_wr_en_o   <= 1'b0;
      mem_wr_addr_o <= '0;
      mem_wr_data_o <= '0;
      wr_ptr        <= '0;
    end else begin
      wr_ack_o    <= wr_grant;
      mem_wr_en_o <= |wr_grant;
      if (|wr_grant) begin
        mem_wr_addr_o <= wr_sel.addr;
        mem_wr_data_o <= wr_sel.data;
        wr_ptr        <= wr_ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_dispmem_arbiter.sv
// Bench for dispmem_arbiter: directed scenarios plus random traffic against a
// scoreboard memory and a cycle-level behavioural model of the arbitration rules.
`timescale 1ns/1ps
module tb_dispmem_arbiter;
  import video_package::*;

  localparam int NW          = 3;
  localparam int NVB         = 2;
  localparam int RAND_CYCLES = 10000;
  localparam int ADDR_SPAN   = 32;

  logic clk = 1'b0;
  logic rst_n, v_visible, preload;
  logic vid_en;  disp_addr_t vid_addr;  disp_data_t vid_data;
  logic host_req; disp_addr_t host_addr; logic host_ack; disp_data_t host_data;
  logic [NW-1:0] wr_req, wr_ack;
  disp_addr_t [NW-1:0] wr_addr;
  disp_data_t [NW-1:0] wr_data;
  logic mem_rd_en; disp_addr_t mem_rd_addr; disp_data_t mem_rd_data;
  logic mem_wr_en; disp_addr_t mem_wr_addr; disp_data_t mem_wr_data;

  logic [NVB-1:0] vb_req, vb_ack;
  disp_addr_t [NVB-1:0] vb_addr;
  disp_data_t [NVB-1:0] vb_data;
  disp_data_t vb_vid_data, vb_host_data;
  logic vb_host_ack, vb_rd_en, vb_wr_en;
  disp_addr_t vb_rd_addr, vb_wr_addr;
  disp_data_t vb_wr_data;

  disp_data_t tbmem   [0:4095];
  disp_data_t ref_mem [0:4095];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dispmem_arbiter #(.NUM_WR(NW), .WR_VBLANK_ONLY(1'b0)) dut (
    .clk(clk), .rst_ni(rst_n), .v_visible_i(v_visible),
    .vid_rd_en_i(vid_en), .vid_rd_addr_i(vid_addr), .vid_rd_data_o(vid_data),
    .host_rd_req_i(host_req), .host_rd_addr_i(host_addr),
    .host_rd_ack_o(host_ack), .host_rd_data_o(host_data),
    .wr_req_i(wr_req), .wr_ack_o(wr_ack), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .mem_rd_en_o(mem_rd_en), .mem_rd_addr_o(mem_rd_addr), .mem_rd_data_i(mem_rd_data),
    .mem_wr_en_o(mem_wr_en), .mem_wr_addr_o(mem_wr_addr), .mem_wr_data_o(mem_wr_data)
  );

  dispmem_arbiter #(.NUM_WR(NVB), .WR_VBLANK_ONLY(1'b1)) dut_vb (
    .clk(clk), .rst_ni(rst_n), .v_visible_i(v_visible),
    .vid_rd_en_i(1'b0), .vid_rd_addr_i(12'h000), .vid_rd_data_o(vb_vid_data),
    .host_rd_req_i(1'b0), .host_rd_addr_i(12'h000),
    .host_rd_ack_o(vb_host_ack), .host_rd_data_o(vb_host_data),
    .wr_req_i(vb_req), .wr_ack_o(vb_ack), .wr_addr_i(vb_addr), .wr_data_i(vb_data),
    .mem_rd_en_o(vb_rd_en), .mem_rd_addr_o(vb_rd_addr), .mem_rd_data_i(8'h00),
    .mem_wr_en_o(vb_wr_en), .mem_wr_addr_o(vb_wr_addr), .mem_wr_data_o(vb_wr_data)
  );

  function automatic disp_data_t pat(input int a);
    return disp_data_t'(a * 7 + 3);
  endfunction

  // Display memory: registered read (old data on same-address write), plain write
  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < 4096; a++) tbmem[a] <= pat(a);
    end else begin
      if (mem_rd_en) mem_rd_data <= tbmem[mem_rd_addr];
      if (mem_wr_en) tbmem[mem_wr_addr] <= mem_wr_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    v_visible = 1'b0; vid_en = 1'b0; vid_addr = '0;
    host_req = 1'b0; host_addr = '0;
    wr_req = '0; wr_addr = '0; wr_data = '0;
    vb_req = '0; vb_addr = '0; vb_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0; preload = 1'b1; vid_en = 1'b1; vid_addr = 12'h033;
    tick();
    preload = 1'b0;
    #1;
    vectors++; if (wr_ack !== '0) begin miscompares++; $display("FAIL rst_wr_ack: got %0h want 0", wr_ack); end
    vectors++; if (mem_wr_en !== 1'b0) begin miscompares++; $display("FAIL rst_mem_wr_en: got %0b want 0", mem_wr_en); end
    vectors++; if (host_ack !== 1'b0) begin miscompares++; $display("FAIL rst_host_ack: got %0b want 0", host_ack); end
    vectors++; if (host_data !== 8'h00) begin miscompares++; $display("FAIL rst_host_data: got %0h want 0", host_data); end
    vectors++; if (vb_ack !== '0 || vb_wr_en !== 1'b0) begin miscompares++; $display("FAIL rst_vb_outputs: got ack %0h en %0b want 0", vb_ack, vb_wr_en); end
    vectors++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 12'h033) begin miscompares++; $display("FAIL rst_vid_passthru: got en %0b addr %0h want 1/033", mem_rd_en, mem_rd_addr); end
    tick();
    vectors++; if (vid_data !== pat(12'h033)) begin miscompares++; $display("FAIL rst_vid_data: got %0h want %0h", vid_data, pat(12'h033)); end
    rst_n = 1'b1; vid_en = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [NW-1:0] exp;
    int idx;
    drive_idle();
    do_reset();
    wr_addr[0] = 12'h100; wr_data[0] = 8'hA0;
    wr_addr[1] = 12'h101; wr_data[1] = 8'hB1;
    wr_addr[2] = 12'h102; wr_data[2] = 8'hC2;
    for (int ph = 2; ph <= 3; ph++) begin
      wr_req = (ph == 2) ? 3'b011 : 3'b111;
      for (int k = 1; k <= 9; k++) begin
        tick();
        idx = (k - 1) % ph;
        exp = '0; exp[idx] = 1'b1;
        vectors++; if (wr_ack !== exp) begin miscompares++; $display("FAIL b2b_ack[%0d/%0d]: got %0b want %0b", ph, k, wr_ack, exp); end
        vectors++; if (mem_wr_en !== 1'b1 || mem_wr_addr !== wr_addr[idx] || mem_wr_data !== wr_data[idx])
          begin miscompares++; $display("FAIL b2b_write[%0d/%0d]: got %0b %0h %0h want 1 %0h %0h", ph, k, mem_wr_en, mem_wr_addr, mem_wr_data, wr_addr[idx], wr_data[idx]); end
      end
      wr_req = '0;
      tick();
      do_reset();
    end
  endtask

  task automatic test_video_priority();
    drive_idle();
    host_req = 1'b1; host_addr = 12'h012; vid_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      vid_addr = disp_addr_t'(12'h040 + k);
      #1;
      vectors++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== vid_addr) begin miscompares++; $display("FAIL vp_busy_addr[%0d]: got %0b %0h want 1 %0h", k, mem_rd_en, mem_rd_addr, vid_addr); end
      vectors++; if (host_ack !== 1'b0) begin miscompares++; $display("FAIL vp_early_ack[%0d]: got %0b want 0", k, host_ack); end
      if (k > 0) begin
        vectors++; if (vid_data !== pat(12'h040 + k - 1)) begin miscompares++; $display("FAIL vp_vid_data[%0d]: got %0h want %0h", k, vid_data, pat(12'h040 + k - 1)); end
      end
      tick();
    end
    vid_en = 1'b0;
    #1;
    vectors++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 12'h012) begin miscompares++; $display("FAIL vp_issue: got %0b %0h want 1 012", mem_rd_en, mem_rd_addr); end
    tick();
    vectors++; if (host_ack !== 1'b0 || mem_rd_en !== 1'b0) begin miscompares++; $display("FAIL vp_gap: got ack %0b rd_en %0b want 0 0", host_ack, mem_rd_en); end
    tick();
    vectors++; if (host_ack !== 1'b1 || host_data !== pat(12'h012)) begin miscompares++; $display("FAIL vp_ack: got %0b %0h want 1 %0h", host_ack, host_data, pat(12'h012)); end
    tick();
    host_req = 1'b0;
    vectors++; if (host_ack !== 1'b0 || host_data !== pat(12'h012)) begin miscompares++; $display("FAIL vp_hold: got %0b %0h want 0 %0h", host_ack, host_data, pat(12'h012)); end
    tick();
  endtask

  task automatic test_write_then_read();
    drive_idle();
    wr_req[1] = 1'b1; wr_addr[1] = 12'h005; wr_data[1] = 8'h41;
    tick();
    vectors++; if (wr_ack !== 3'b010 || mem_wr_en !== 1'b1 || mem_wr_addr !== 12'h005 || mem_wr_data !== 8'h41)
      begin miscompares++; $display("FAIL wr1: got ack %0b en %0b %0h %0h want 010 1 005 41", wr_ack, mem_wr_en, mem_wr_addr, mem_wr_data); end
    tick();
    wr_req = '0; host_req = 1'b1; host_addr = 12'h005;
    vectors++; if (wr_ack !== '0) begin miscompares++; $display("FAIL wr1_ack_width: got %0b want 0", wr_ack); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++; if (host_ack !== (k == 3)) begin miscompares++; $display("FAIL rd_latency[%0d]: got %0b want %0b", k, host_ack, k == 3); end
    end
    vectors++; if (host_data !== 8'h41) begin miscompares++; $display("FAIL rd_after_wr: got %0h want 41", host_data); end
    tick();
    host_req = 1'b0;
    tick();
  endtask

  task automatic test_vblank();
    drive_idle();
    v_visible = 1'b1;
    vb_req[0] = 1'b1; vb_addr[0] = 12'h020; vb_data[0] = 8'h5C;
    for (int k = 0; k < 6; k++) begin
      tick();
      vectors++; if (vb_ack !== '0 || vb_wr_en !== 1'b0) begin miscompares++; $display("FAIL vb_blocked[%0d]: got %0b %0b want 0 0", k, vb_ack, vb_wr_en); end
    end
    v_visible = 1'b0;
    tick();
    vectors++; if (vb_ack !== 2'b01 || vb_wr_en !== 1'b1 || vb_wr_addr !== 12'h020 || vb_wr_data !== 8'h5C)
      begin miscompares++; $display("FAIL vb_release: got %0b %0b %0h %0h want 01 1 020 5c", vb_ack, vb_wr_en, vb_wr_addr, vb_wr_data); end
    tick();
    vb_req[0] = 1'b0;
    vb_req[1] = 1'b1; vb_addr[1] = 12'h021; vb_data[1] = 8'h6D;
    tick();
    v_visible = 1'b1;
    vectors++; if (vb_ack !== 2'b10 || vb_wr_en !== 1'b1 || vb_wr_data !== 8'h6D)
      begin miscompares++; $display("FAIL vb_inflight: got %0b %0b %0h want 10 1 6d", vb_ack, vb_wr_en, vb_wr_data); end
    tick();
    vb_req[1] = 1'b0;
    vectors++; if (vb_ack !== '0 || vb_wr_en !== 1'b0) begin miscompares++; $display("FAIL vb_after: got %0b %0b want 0 0", vb_ack, vb_wr_en); end
    v_visible = 1'b0;
    tick();
  endtask

  task automatic test_reset_midop();
    drive_idle();
    vid_en = 1'b1; vid_addr = 12'h050; host_req = 1'b1; host_addr = 12'h013;
    tick();
    wr_req[0] = 1'b1; wr_addr[0] = 12'h030; wr_data[0] = 8'h77;
    rst_n = 1'b0;
    tick();
    vectors++; if (wr_ack !== '0 || mem_wr_en !== 1'b0 || host_ack !== 1'b0 || host_data !== 8'h00)
      begin miscompares++; $display("FAIL midop_rst: got %0b %0b %0b %0h want all 0", wr_ack, mem_wr_en, host_ack, host_data); end
    rst_n = 1'b1; drive_idle();
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++; if (mem_rd_en !== 1'b0 || host_ack !== 1'b0 || wr_ack !== '0 || mem_wr_en !== 1'b0)
        begin miscompares++; $display("FAIL midop_quiet[%0d]: got rd %0b hack %0b wack %0b wen %0b want 0", k, mem_rd_en, host_ack, wr_ack, mem_wr_en); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [NW-1:0] exp_ack, nxt_ack, drop;
    int last_g, h_phase, h_ack_at, n;
    bit vid_pend, h_issue, h_drop, h_acked, acked;
    disp_data_t vid_exp, h_exp, h_last, acked_data;
    disp_addr_t acked_addr;
    drive_idle();
    preload = 1'b1;
    tick();
    preload = 1'b0;
    for (int a = 0; a < 4096; a++) ref_mem[a] = pat(a);
    exp_ack = '0; drop = '0; last_g = NW - 1;
    vid_pend = 1'b0; vid_exp = '0;
    h_phase = 0; h_ack_at = -1; h_exp = '0; h_last = 8'h00; h_drop = 1'b0;
    for (int c = 0; c < RAND_CYCLES; c++) begin
      tick();
      vectors++; if (wr_ack !== exp_ack) begin miscompares++; $display("FAIL rnd_wr_ack@%0d: got %0b want %0b", c, wr_ack, exp_ack); end
      vectors++; if (mem_wr_en !== (exp_ack != '0)) begin miscompares++; $display("FAIL rnd_wr_en@%0d: got %0b want %0b", c, mem_wr_en, exp_ack != '0); end
      acked = 1'b0; acked_addr = '0; acked_data = '0;
      for (int i = 0; i < NW; i++) if (exp_ack[i]) begin acked = 1'b1; acked_addr = wr_addr[i]; acked_data = wr_data[i]; end
      if (acked) begin
        vectors++; if (mem_wr_addr !== acked_addr || mem_wr_data !== acked_data)
          begin miscompares++; $display("FAIL rnd_wr_payload@%0d: got %0h %0h want %0h %0h", c, mem_wr_addr, mem_wr_data, acked_addr, acked_data); end
      end
      if (vid_pend) begin
        vectors++; if (vid_data !== vid_exp) begin miscompares++; $display("FAIL rnd_vid_data@%0d: got %0h want %0h", c, vid_data, vid_exp); end
      end
      h_acked = (h_ack_at == c);
      vectors++; if (host_ack !== h_acked) begin miscompares++; $display("FAIL rnd_host_ack@%0d: got %0b want %0b", c, host_ack, h_acked); end
      if (h_acked) begin h_last = h_exp; h_phase = 0; end
      vectors++; if (host_data !== h_last) begin miscompares++; $display("FAIL rnd_host_data@%0d: got %0h want %0h", c, host_data, h_last); end
      // Writers drop the cycle after their ack, otherwise may raise a new request
      for (int i = 0; i < NW; i++) begin
        if (drop[i]) wr_req[i] = 1'b0;
        else if (!wr_req[i] && $urandom_range(3) == 0) begin
          wr_req[i]  = 1'b1;
          wr_addr[i] = disp_addr_t'($urandom_range(ADDR_SPAN - 1));
          wr_data[i] = disp_data_t'($urandom);
        end
      end
      drop = exp_ack;
      vid_en    = ($urandom_range(9) < 6);
      vid_addr  = disp_addr_t'($urandom_range(ADDR_SPAN - 1));
      v_visible = 1'($urandom_range(1));
      // Host read goes out in the first video-idle cycle after the request cycle
      h_issue = (h_phase == 1) && !vid_en;
      if (h_issue) begin h_exp = ref_mem[host_addr]; h_ack_at = c + 2; h_phase = 2; end
      if (h_drop) begin host_req = 1'b0; h_drop = 1'b0; end
      else if (h_phase == 0 && !host_req && $urandom_range(7) == 0) begin
        host_req = 1'b1; host_addr = disp_addr_t'($urandom_range(ADDR_SPAN - 1)); h_phase = 1;
      end
      if (h_acked) h_drop = 1'b1;
      #1;
      vectors++; if (mem_rd_en !== (vid_en | h_issue)) begin miscompares++; $display("FAIL rnd_rd_en@%0d: got %0b want %0b", c, mem_rd_en, vid_en | h_issue); end
      if (vid_en || h_issue) begin
        vectors++; if (mem_rd_addr !== (vid_en ? vid_addr : host_addr))
          begin miscompares++; $display("FAIL rnd_rd_addr@%0d: got %0h want %0h", c, mem_rd_addr, vid_en ? vid_addr : host_addr); end
      end
      vid_pend = vid_en;
      if (vid_en) vid_exp = ref_mem[vid_addr];
      // Next grant: first eligible requester after the last winner, wrapping
      nxt_ack = '0;
      for (int i = 1; i <= NW; i++) begin
        n = (last_g + i) % NW;
        if (nxt_ack == '0 && wr_req[n] && !exp_ack[n]) begin nxt_ack[n] = 1'b1; last_g = n; end
      end
      if (acked) ref_mem[acked_addr] = acked_data;
      exp_ack = nxt_ack;
    end
    drive_idle();
    tick();
  endtask

  initial begin
    preload = 1'b0;
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_back_to_back();
    test_video_priority();
    test_write_then_read();
    test_vblank();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
